// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the two-port burst-read arbiter
interface mem_arbiter_if;
    logic [31:0] req0_rdaddr;
    logic        req0_rdreq;
    logic [31:0] req0_dataout;
    logic        req0_datavalid;
    logic        req0_busy;
    logic [31:0] req1_rdaddr;
    logic        req1_rdreq;
    logic [31:0] req1_dataout;
    logic        req1_datavalid;
    logic        req1_busy;
    logic [31:0] mem_rdaddr;
    logic        mem_rdreq;
    logic [31:0] mem_dataout;
    logic        mem_datavalid;

    modport master (
        input  req0_rdaddr, req0_rdreq, req1_rdaddr, req1_rdreq, mem_dataout, mem_datavalid,
        output req0_dataout, req0_datavalid, req0_busy,
        output req1_dataout, req1_datavalid, req1_busy,
        output mem_rdaddr, mem_rdreq
    );

    modport slave (
        output req0_rdaddr, req0_rdreq, req1_rdaddr, req1_rdreq, mem_dataout, mem_datavalid,
        input  req0_dataout, req0_datavalid, req0_busy,
        input  req1_dataout, req1_datavalid, req1_busy,
        input  mem_rdaddr, mem_rdreq
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one burst-read memory port between icache and dcache
module mem_arbiter #(
    parameter int BURST_LEN = 32,
    parameter int CNT_W     = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

    state_t           state_q, state_d;
    logic [1:0]       pend_q, pend_d;
    logic [31:0]      addr0_q, addr0_d, addr1_q, addr1_d;
    logic             grant_q, grant_d, last_q, last_d;
    logic             rdreq_q, rdreq_d;
    logic [31:0]      rdaddr_q, rdaddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pulse;
    logic             last_beat;

    assign pulse     = {bus.req1_rdreq, bus.req0_rdreq};
    assign last_beat = state_q == BURST && bus.mem_datavalid && cnt_q == CNT_W'(BURST_LEN - 1);

    always_comb begin
        pend_d   = pend_q | pulse;
        addr0_d  = (pulse[0] && !pend_q[0]) ? bus.req0_rdaddr : addr0_q;
        addr1_d  = (pulse[1] && !pend_q[1]) ? bus.req1_rdaddr : addr1_q;
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        rdaddr_d = rdaddr_q;
        rdreq_d  = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (|pend_q) begin
                grant_d  = &pend_q ? !last_q : pend_q[1];
                rdaddr_d = grant_d ? addr1_q : addr0_q;
                rdreq_d  = 1'b1;
                state_d  = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = BURST;
            end
            BURST: if (bus.mem_datavalid) begin
                cnt_d = cnt_q + 1'b1;
                // clearing after the capture OR means a same-edge pulse from the served port is lost
                if (last_beat) begin
                    pend_d[grant_q] = 1'b0;
                    last_d          = grant_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            rdreq_q  <= 1'b0;
            rdaddr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            rdreq_q  <= rdreq_d;
            rdaddr_q <= rdaddr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.mem_rdaddr     = rdaddr_q;
    assign bus.mem_rdreq      = rdreq_q;
    assign bus.req0_dataout   = bus.mem_dataout;
    assign bus.req1_dataout   = bus.mem_dataout;
    assign bus.req0_datavalid = bus.mem_datavalid && state_q == BURST && !grant_q;
    assign bus.req1_datavalid = bus.mem_datavalid && state_q == BURST && grant_q;
    assign bus.req0_busy      = pend_q[0];
    assign bus.req1_busy      = pend_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a burst memory model behind the arbiter
module tb_mem_arbiter;
    localparam int BL = 32;

    typedef struct packed {
        logic        p;
        logic [31:0] v;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset_n;
    exp_t  gq[$];
    exp_t  bq[$];
    int    vectors = 0;
    int    errors = 0;
    logic  last_p = 1'b1;
    int    extra = 0;
    int    beat_idx = 0;
    logic  mem_busy = 1'b0;

    mem_arbiter_if bus ();

    mem_arbiter #(.BURST_LEN(BL), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_rdreq"}, 32'(bus.mem_rdreq), 0);
        chk({t, "_rdaddr"}, bus.mem_rdaddr, 0);
        chk({t, "_dv0"}, 32'(bus.req0_datavalid), 0);
        chk({t, "_dv1"}, 32'(bus.req1_datavalid), 0);
        chk({t, "_busy0"}, 32'(bus.req0_busy), 0);
        chk({t, "_busy1"}, 32'(bus.req1_busy), 0);
    endtask

    task automatic chk_empty(input string t);
        chk({t, "_grants_left"}, 32'(gq.size()), 0);
        chk({t, "_beats_left"}, 32'(bq.size()), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        gq.delete();
        bq.delete();
        last_p = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("rst");
        reset_n = 1'b1;
    endtask

    task automatic pulse(input logic p, input logic [31:0] a);
        if (p) begin
            bus.req1_rdaddr = a;
            bus.req1_rdreq  = 1'b1;
        end else begin
            bus.req0_rdaddr = a;
            bus.req0_rdreq  = 1'b1;
        end
        @(posedge clk);
        #1;
        if (p) bus.req1_rdreq = 1'b0;
        else   bus.req0_rdreq = 1'b0;
    endtask

    task automatic pulse2(input logic [31:0] a0, input logic [31:0] a1);
        bus.req0_rdaddr = a0;
        bus.req1_rdaddr = a1;
        bus.req0_rdreq  = 1'b1;
        bus.req1_rdreq  = 1'b1;
        @(posedge clk);
        #1;
        bus.req0_rdreq = 1'b0;
        bus.req1_rdreq = 1'b0;
    endtask

    task automatic push_both(input logic [31:0] a0, input logic [31:0] a1);
        if (last_p) begin
            gq.push_back({1'b0, a0});
            gq.push_back({1'b1, a1});
        end else begin
            gq.push_back({1'b1, a1});
            gq.push_back({1'b0, a0});
        end
    endtask

    task automatic wait_idle(input string t);
        int n = 0;
        while ((mem_busy || bus.req0_busy || bus.req1_busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({t, "_idle_timeout"}, 32'(n >= 3000), 0);
    endtask

    task automatic wait_beat(input int b);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.mem_datavalid && beat_idx == b) && n < 500);
        chk("beat_wait_timeout", 32'(n >= 500), 0);
    endtask

    // memory model: answers each mem_rdreq with BL(+extra) beats, data = address + beat index
    initial begin
        logic [31:0] a;
        int i;
        bus.mem_datavalid = 1'b0;
        bus.mem_dataout   = '0;
        forever begin
            @(negedge clk);
            if (reset_n && bus.mem_rdreq) begin
                a = bus.mem_rdaddr;
                mem_busy = 1'b1;
                i = 0;
                @(posedge clk);
                #1;
                while (i < BL + extra) begin
                    if (i > 0 && i < BL && $urandom_range(0, 3) == 0) bus.mem_datavalid = 1'b0;
                    else begin
                        bus.mem_datavalid = 1'b1;
                        bus.mem_dataout   = a + 32'(i);
                        beat_idx = i;
                        i++;
                    end
                    @(posedge clk);
                    #1;
                end
                bus.mem_datavalid = 1'b0;
                mem_busy = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        logic prev_rdreq = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.mem_rdreq) begin
                    chk("rdreq_one_cycle", 32'(prev_rdreq), 0);
                    if (gq.size() == 0) chk("grant_unexpected", 32'(gq.size()), 1);
                    else begin
                        e = gq.pop_front();
                        chk("mem_rdaddr", bus.mem_rdaddr, e.v);
                        last_p = e.p;
                        for (int i = 0; i < BL; i++) bq.push_back({e.p, e.v + 32'(i)});
                    end
                end
                if (bus.req0_datavalid || bus.req1_datavalid) begin
                    chk("dv_both_ports", 32'(bus.req0_datavalid && bus.req1_datavalid), 0);
                    if (bq.size() == 0) chk("beat_unexpected", 32'(bq.size()), 1);
                    else begin
                        e = bq.pop_front();
                        chk("beat_port", 32'(bus.req1_datavalid), 32'(e.p));
                        chk("beat_data", bus.req1_datavalid ? bus.req1_dataout : bus.req0_dataout, e.v);
                    end
                end
            end
            prev_rdreq = bus.mem_rdreq;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        reset_n = 1'b0;
        bus.req0_rdreq  = 1'b0;
        bus.req1_rdreq  = 1'b0;
        bus.req0_rdaddr = '0;
        bus.req1_rdaddr = '0;
        @(posedge clk);
        do_reset();

        // single port0 request: latency, busy rise, burst delivery
        gq.push_back({1'b0, 32'h0});
        chk("busy0_before", 32'(bus.req0_busy), 0);
        bus.req0_rdaddr = 32'h0;
        bus.req0_rdreq  = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            bus.req0_rdreq = 1'b0;
            lat++;
            if (lat == 1) chk("busy0_rise", 32'(bus.req0_busy), 1);
        end while (!bus.mem_rdreq && lat < 10);
        chk("rdreq_latency", 32'(lat), 2);
        wait_idle("t1");
        chk("t1_busy0", 32'(bus.req0_busy), 0);
        chk_empty("t1");

        // simultaneous pulses right after reset: port0 first
        do_reset();
        push_both(32'h100, 32'h2000_0000);
        pulse2(32'h100, 32'h2000_0000);
        wait_idle("t2");
        chk_empty("t2");

        // port1 arrives mid-burst; port0 re-pulses on its own final beat
        gq.push_back({1'b0, 32'h0000_4000});
        pulse(1'b0, 32'h0000_4000);
        wait_beat(5);
        gq.push_back({1'b1, 32'h1234_5600});
        pulse(1'b1, 32'h1234_5600);
        wait_beat(31);
        pulse(1'b0, 32'h0BAD_0000);
        wait_idle("t3");
        chk("t3_busy0", 32'(bus.req0_busy), 0);
        chk_empty("t3");

        // memory overruns by one beat
        extra = 1;
        gq.push_back({1'b1, 32'h0000_5000});
        pulse(1'b1, 32'h0000_5000);
        wait_idle("t4");
        extra = 0;
        chk_empty("t4");

        // asynchronous reset mid-burst
        gq.push_back({1'b0, 32'h0000_0040});
        pulse(1'b0, 32'h0000_0040);
        wait_beat(10);
        #1;
        reset_n = 1'b0;
        #1;
        chk_zero("arst");
        gq.delete();
        bq.delete();
        last_p = 1'b1;
        reset_n = 1'b1;
        wait_idle("t5a");
        gq.push_back({1'b1, 32'h3000_0000});
        pulse(1'b1, 32'h3000_0000);
        wait_idle("t5b");
        chk_empty("t5");

        // saturation: each port re-pulses as soon as its busy falls
        for (int r = 0; r < 4; r++) push_both(32'hA000_0000 + 32'(r) * 32'h1000, 32'hB000_0000 + 32'(r) * 32'h1000);
        fork
            begin
                for (int r = 0; r < 4; r++) begin
                    int n = 0;
                    pulse(1'b0, 32'hA000_0000 + 32'(r) * 32'h1000);
                    while (bus.req0_busy && n < 3000) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    chk("sat0_timeout", 32'(n >= 3000), 0);
                end
            end
            begin
                for (int r = 0; r < 4; r++) begin
                    int n = 0;
                    pulse(1'b1, 32'hB000_0000 + 32'(r) * 32'h1000);
                    while (bus.req1_busy && n < 3000) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    chk("sat1_timeout", 32'(n >= 3000), 0);
                end
            end
        join
        wait_idle("t6");
        chk_empty("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
